// File: rtl/shake_pkg.sv
// ---------------------------------------------------------------------------
// shake_pkg
// Shared types and constants for the SHAKE absorb front end.
//   lane_t          one 64-bit Keccak lane
//   state_t         5x5 lane state, indexed [x][y]; lane i sits at x = i%5, y = i/5
//   RATE128_L/256_L rate in lanes for SHAKE128 / SHAKE256
//   DSEP_*, PAD_END domain-separation bytes and the closing pad byte
//   absorb_state_e  absorb controller states
// ---------------------------------------------------------------------------
package shake_pkg;

  localparam int LANE_W    = 64;   // only 64-bit lanes are supported
  localparam int NLANES    = 25;
  localparam int RATE128_L = 21;
  localparam int RATE256_L = 17;

  localparam logic [7:0] DSEP_SHAKE = 8'h1F;
  localparam logic [7:0] DSEP_SHA3  = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [0:4][0:4]  state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_PERM,
    ST_DONE
  } absorb_state_e;

endpackage

// File: rtl/shake_pad_lane.sv
// ---------------------------------------------------------------------------
// shake_pad_lane
// Combinational padding for one lane: keeps the first nbytes message bytes,
// zeroes the rest, XORs the domain byte at byte position nbytes and
// optionally XORs 0x80 into byte 7. When both land on byte 7 they combine
// by XOR (e.g. 0x1F ^ 0x80 = 0x9F).
//   data    in   lane_t  raw input lane (little-endian bytes)
//   nbytes  in   4       bytes to keep (0..8)
//   dom_en  in   1       insert the domain byte at byte nbytes (needs nbytes < 8)
//   dom     in   8       domain-separation byte
//   end_en  in   1       insert 0x80 at byte 7
//   lane    out  lane_t  padded lane
// ---------------------------------------------------------------------------
module shake_pad_lane
  import shake_pkg::*;
(
  input  lane_t       data,
  input  logic [3:0]  nbytes,
  input  logic        dom_en,
  input  logic [7:0]  dom,
  input  logic        end_en,
  output lane_t       lane
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    localparam logic [3:0] BI = 4'(gi);
    logic [7:0] keep;
    logic [7:0] dsep;
    logic [7:0] pend;

    assign keep = (BI < nbytes) ? data[8*gi +: 8] : 8'h00;
    assign dsep = (dom_en && (BI == nbytes)) ? dom : 8'h00;
    assign pend = (end_en && (BI == 4'd7)) ? PAD_END : 8'h00;
    assign lane[8*gi +: 8] = keep ^ dsep ^ pend;
  end

endmodule

// File: rtl/shake_absorb.sv
// ---------------------------------------------------------------------------
// shake_absorb
// Absorb stage in front of the Keccak-f[1600] round datapath. Message lanes
// are XORed into the 5x5 state; the final block is padded with the domain
// byte and a closing 0x80 in the last rate byte. Each full rate block is
// handed to the permutation with a start/done handshake and the permuted
// state is written back. In DONE the absorbed state is held for squeezing.
//
// Optional feature: define SHAKE_ABSORB_SHA3_EN to add sha3_i, which selects
// the SHA-3 domain byte (0x06) instead of the SHAKE one (0x1F).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin a message (only in IDLE or DONE)
//   mode_i          0 = SHAKE128 (21-lane rate), 1 = SHAKE256 (17-lane rate)
//   in_valid_i/in_ready_o/in_data_i/in_last_i/in_bytes_i  lane stream
//   state_o         current state, [x][y]
//   perm_start_o    one-cycle permutation request
//   perm_done_i     permutation finished, perm_state_i valid
//   perm_state_i    permuted state, [x][y]
//   sha3_i          (SHAKE_ABSORB_SHA3_EN only) SHA-3 domain select
//   busy_o          not in IDLE/DONE
//   absorb_done_o   in DONE
// ---------------------------------------------------------------------------
module shake_absorb
  import shake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  lane_t       in_data_i,
  input  logic        in_last_i,
  input  logic [3:0]  in_bytes_i,
  output state_t      state_o,
  output logic        perm_start_o,
  input  logic        perm_done_i,
  input  state_t      perm_state_i,
`ifdef SHAKE_ABSORB_SHA3_EN
  input  logic        sha3_i,
`endif
  output logic        busy_o,
  output logic        absorb_done_o
);

  localparam lane_t END_LANE = {PAD_END, 56'h0};

  absorb_state_e fsm_reg, fsm_next;
  state_t        state_reg;
  logic [4:0]    lane_cnt_reg;
  logic          final_f_reg;
  logic          pad_pend_reg;
  logic          mode_reg;
  logic          perm_issued_reg;   // already in PERM last cycle -> start was sent

  logic [4:0]    rate_m1;
  logic [3:0]    nbytes_eff;
  logic          take;
  logic          at_end;
  logic [7:0]    dom;

  // padding control
  lane_t         pad_data;
  logic [3:0]    pad_nbytes;
  logic          pad_dom_en;
  logic          end_en;
  logic          wr_en;
  lane_t         pad_lane;
  lane_t         upd [NLANES];

`ifdef SHAKE_ABSORB_SHA3_EN
  logic sha3_reg;
  assign dom = sha3_reg ? DSEP_SHA3 : DSEP_SHAKE;
`else
  assign dom = DSEP_SHAKE;
`endif

  assign rate_m1    = mode_reg ? 5'(RATE256_L - 1) : 5'(RATE128_L - 1);
  assign nbytes_eff = (in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i;
  assign take       = (fsm_reg == ST_ABSORB) && in_valid_i;
  assign at_end     = (lane_cnt_reg == rate_m1);

  // A short final lane carries its own domain byte; a PAD cycle writes the
  // domain byte into an otherwise empty lane. Both also close the block.
  always_comb begin
    pad_data   = in_data_i;
    pad_nbytes = 4'd8;
    pad_dom_en = 1'b0;
    end_en     = 1'b0;
    wr_en      = 1'b0;
    if (take) begin
      wr_en = 1'b1;
      if (in_last_i && (nbytes_eff != 4'd8)) begin
        pad_nbytes = nbytes_eff;
        pad_dom_en = 1'b1;
        end_en     = 1'b1;
      end
    end else if (fsm_reg == ST_PAD) begin
      pad_data   = '0;
      pad_nbytes = 4'd0;
      pad_dom_en = 1'b1;
      end_en     = 1'b1;
      wr_en      = 1'b1;
    end
  end

  // 0x80 is folded into the padded lane when the target lane is the last
  // rate lane, otherwise it is XORed separately into lane rate-1.
  shake_pad_lane u_pad (
    .data   (pad_data),
    .nbytes (pad_nbytes),
    .dom_en (pad_dom_en),
    .dom    (dom),
    .end_en (end_en && at_end),
    .lane   (pad_lane)
  );

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    localparam logic [4:0] IDX = 5'(gi);
    assign upd[gi] = state_reg[gi % 5][gi / 5]
                   ^ ((wr_en && (lane_cnt_reg == IDX)) ? pad_lane : '0)
                   ^ ((end_en && !at_end && (rate_m1 == IDX)) ? END_LANE : '0);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg         <= ST_IDLE;
      perm_issued_reg <= 1'b0;
    end else begin
      fsm_reg         <= fsm_next;
      perm_issued_reg <= (fsm_reg == ST_PERM);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      ST_IDLE, ST_DONE: begin
        if (start_i) fsm_next = ST_ABSORB;
      end
      ST_ABSORB: begin
        if (take) begin
          if (in_last_i) begin
            if ((nbytes_eff != 4'd8) || at_end) fsm_next = ST_PERM;
            else                                fsm_next = ST_PAD;
          end else if (at_end) begin
            fsm_next = ST_PERM;
          end
        end
      end
      ST_PAD:  fsm_next = ST_PERM;
      ST_PERM: begin
        if (perm_done_i) begin
          if (final_f_reg)       fsm_next = ST_DONE;
          else if (pad_pend_reg) fsm_next = ST_PAD;
          else                   fsm_next = ST_ABSORB;
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready_o    = (fsm_reg == ST_ABSORB);
    perm_start_o  = (fsm_reg == ST_PERM) && !perm_issued_reg;
    busy_o        = (fsm_reg != ST_IDLE) && (fsm_reg != ST_DONE);
    absorb_done_o = (fsm_reg == ST_DONE);
  end

  assign state_o = state_reg;

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= '0;
      lane_cnt_reg <= '0;
      final_f_reg  <= 1'b0;
      pad_pend_reg <= 1'b0;
      mode_reg     <= 1'b0;
`ifdef SHAKE_ABSORB_SHA3_EN
      sha3_reg     <= 1'b0;
`endif
    end else begin
      case (fsm_reg)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_reg    <= '0;
            lane_cnt_reg <= '0;
            final_f_reg  <= 1'b0;
            pad_pend_reg <= 1'b0;
            mode_reg     <= mode_i;
`ifdef SHAKE_ABSORB_SHA3_EN
            sha3_reg     <= sha3_i;
`endif
          end
        end
        ST_ABSORB: begin
          if (take) begin
            for (int i = 0; i < NLANES; i++) state_reg[i % 5][i / 5] <= upd[i];
            lane_cnt_reg <= lane_cnt_reg + 5'd1;
            if (in_last_i) begin
              if (nbytes_eff != 4'd8) final_f_reg  <= 1'b1;
              else if (at_end)        pad_pend_reg <= 1'b1;  // padding needs a block of its own
            end else if (at_end) begin
              final_f_reg <= 1'b0;
            end
          end
        end
        ST_PAD: begin
          for (int i = 0; i < NLANES; i++) state_reg[i % 5][i / 5] <= upd[i];
          final_f_reg <= 1'b1;
        end
        ST_PERM: begin
          if (perm_done_i) begin
            state_reg    <= perm_state_i;
            lane_cnt_reg <= '0;
            if (!final_f_reg) pad_pend_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_absorb.sv
// ---------------------------------------------------------------------------
// tb_shake_absorb
// Directed bench for shake_absorb with an identity permutation model.
// Expected lanes come from a byte-level SHAKE padding model and are queued
// when a message is driven, then popped and compared once absorb_done_o rises.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shake_absorb;
  import shake_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        mode_i;
  logic        in_valid_i;
  logic        in_ready_o;
  lane_t       in_data_i;
  logic        in_last_i;
  logic [3:0]  in_bytes_i;
  state_t      state_o;
  logic        perm_start_o;
  logic        perm_done_i;
  state_t      perm_state_i;
  logic        busy_o;
  logic        absorb_done_o;
`ifdef SHAKE_ABSORB_SHA3_EN
  logic        sha3_i;
`endif

  always #5 clk = ~clk;

  shake_absorb dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .in_last_i     (in_last_i),
    .in_bytes_i    (in_bytes_i),
    .state_o       (state_o),
    .perm_start_o  (perm_start_o),
    .perm_done_i   (perm_done_i),
    .perm_state_i  (perm_state_i),
`ifdef SHAKE_ABSORB_SHA3_EN
    .sha3_i        (sha3_i),
`endif
    .busy_o        (busy_o),
    .absorb_done_o (absorb_done_o)
  );

  typedef struct {
    string       tag;
    int          idx;
    logic [63:0] exp;
  } sb_t;

  sb_t   sb_q[$];
  lane_t msg[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    n_fail = 0;
  int    perm_cnt = 0;
  int    ready_viol = 0;
  int    done_delay = 3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back({$urandom, $urandom});
  endtask

  // Identity permutation: returns the state seen at the start pulse after
  // done_delay cycles. Input must never be accepted while it is pending.
  initial begin : perm_model
    state_t snap;
    perm_done_i  = 1'b0;
    perm_state_i = '0;
    forever begin
      @(negedge clk);
      if (perm_start_o && !rst) begin
        snap = state_o;
        perm_cnt++;
        for (int d = 0; d < done_delay; d++) begin
          @(negedge clk);
          if (in_ready_o || perm_start_o) ready_viol++;
        end
        perm_state_i = snap;
        perm_done_i  = 1'b1;
        @(negedge clk);
        perm_done_i  = 1'b0;
      end
    end
  end

  // Drive the lanes in msg as one message and check the absorbed state.
  task automatic run_msg(input string name, input bit mode, input bit sha3,
                         input logic [3:0] nb, input int delay);
    int          n;
    int          rb;
    int          nbc;
    int          len;
    int          plen;
    int          p0;
    int          w;
    logic [7:0]  st [200];
    logic [7:0]  b;
    logic [7:0]  dsep;
    lane_t       tmp;
    lane_t       lv;
    sb_t         e;

    n    = msg.size();
    rb   = (mode ? 17 : 21) * 8;
    nbc  = (nb > 4'd8) ? 8 : int'(nb);
    len  = 8 * (n - 1) + nbc;
    plen = ((len + rb) / rb) * rb;
    dsep = sha3 ? 8'h06 : 8'h1F;
    for (int k = 0; k < 200; k++) st[k] = 8'h00;
    for (int k = 0; k < plen; k++) begin
      tmp = msg[k / 8];
      b = (k < len) ? tmp[8 * (k % 8) +: 8] : 8'h00;
      if (k == len)      b = b ^ dsep;
      if (k == plen - 1) b = b ^ 8'h80;
      st[k % rb] = st[k % rb] ^ b;
    end
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 8; j++) lv[8 * j +: 8] = st[8 * i + j];
      e.tag = $sformatf("%s lane%0d", name, i);
      e.idx = i;
      e.exp = lv;
      sb_q.push_back(e);
    end

    done_delay = delay;
    p0 = perm_cnt;
    start_i = 1'b1;
    mode_i  = mode;
`ifdef SHAKE_ABSORB_SHA3_EN
    sha3_i  = sha3;
`endif
    @(negedge clk);
    start_i = 1'b0;
    check({name, " busy"}, 64'(busy_o), 64'd1);

    for (int i = 0; i < n; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = msg[i];
      in_last_i  = (i == n - 1);
      in_bytes_i = (i == n - 1) ? nb : 4'd5;
      w = 0;
      while (!in_ready_o && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 1000) begin
        check({name, " ready timeout"}, 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;

    w = 0;
    while (!absorb_done_o && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check({name, " absorb_done"}, 64'(absorb_done_o), 64'd1);
    check({name, " perm count"}, 64'(perm_cnt - p0), 64'(plen / rb));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, state_o[e.idx % 5][e.idx / 5], e.exp);
    end
    $display("msg %s: mode=%0d lanes=%0d last_bytes=%0d perms=%0d",
             name, mode, n, nb, perm_cnt - p0);
  endtask

  initial begin : stim
    int p0;
    rst        = 1'b1;
    start_i    = 1'b0;
    mode_i     = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_last_i  = 1'b0;
    in_bytes_i = 4'd0;
`ifdef SHAKE_ABSORB_SHA3_EN
    sha3_i     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset state", 64'(|state_o), 64'd0);
    check("reset in_ready", 64'(in_ready_o), 64'd0);
    check("reset perm_start", 64'(perm_start_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset absorb_done", 64'(absorb_done_o), 64'd0);

    // 1: one empty final lane
    fill(1);
    run_msg("t1", 1'b0, 1'b0, 4'd0, 3);
    check("t1 s00", state_o[0][0], 64'h1F);
    check("t1 s04", state_o[0][4], 64'h80 << 56);

    // 2: full SHAKE256 block, padding needs a second block
    fill(17);
    run_msg("t2", 1'b1, 1'b0, 4'd8, 4);
    check("t2 s00", state_o[0][0], msg[0] ^ 64'h1F);
    check("t2 s13", state_o[1][3], msg[16] ^ (64'h80 << 56));

    // 3: domain and end byte share byte 7 of the last rate lane
    fill(21);
    msg[20] = 64'hFFAABBCCDDEEFF11;
    run_msg("t3", 1'b0, 1'b0, 4'd7, 2);
    check("t3 s04", state_o[0][4], 64'h9FAABBCCDDEEFF11);

    // 4: multi-block, valid held high while a slow permutation runs
    fill(45);
    run_msg("t4", 1'b0, 1'b0, 4'd3, 30);

    // extra: full final lane mid-block (PAD cycle), and oversize byte count
    fill(20);
    run_msg("pad", 1'b1, 1'b0, 4'd8, 1);
    fill(5);
    run_msg("clamp", 1'b0, 1'b0, 4'd12, 2);
    fill(34);
    run_msg("pend", 1'b1, 1'b0, 4'd8, 2);

    // 5: reset part-way through a message
    fill(5);
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = msg[i];
      in_last_i  = 1'b0;
      in_bytes_i = 4'd0;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    check("t5 mid state nonzero", 64'(|state_o), 64'd1);
    p0 = perm_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 state cleared", 64'(|state_o), 64'd0);
    check("t5 busy", 64'(busy_o), 64'd0);
    check("t5 in_ready", 64'(in_ready_o), 64'd0);
    repeat (5) @(negedge clk);
    check("t5 no perm", 64'(perm_cnt - p0), 64'd0);
    $display("msg t5: reset after 5 lanes");

    fill(1);
    run_msg("t5b", 1'b0, 1'b0, 4'd0, 3);
    check("t5b s00", state_o[0][0], 64'h1F);

`ifdef SHAKE_ABSORB_SHA3_EN
    // 6: SHA-3 domain byte
    fill(1);
    run_msg("t6", 1'b0, 1'b1, 4'd0, 3);
    check("t6 s00", state_o[0][0], 64'h06);
`endif

    check("t4 ready/start while perm pending", 64'(ready_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
